// File: rtl/drum_sequencer.sv
// drum_sequencer: three-voice, 16-step pattern sequencer. Each step lasts a
// tempo-programmed number of clock cycles; go pulses once per step entry.
module drum_sequencer #(
  parameter int NUM_STEPS = 16,
  parameter int TEMPO_W   = 23
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               pause,
  input  logic               stop,
  input  logic [TEMPO_W-1:0] tempo,
  input  logic               wr_en,
  input  logic [1:0]         wr_voice,
  input  logic [15:0]        wr_data,
  output logic [2:0]         go,
  output logic [3:0]         step,
  output logic               bar_start,
  output logic               running
);

  // state  | meaning
  // IDLE   | stopped at step 0, waiting for start
  // RUN    | counting ticks, advancing steps, firing go
  // PAUSED | step and tick frozen, waiting for start to resume
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [TEMPO_W-1:0] tick;
  logic [TEMPO_W-1:0] t_lim;
  logic [TEMPO_W-1:0] tempo_eff;
  logic [15:0]        pat0, pat1, pat2;
  logic [3:0]         step_nxt;
  logic [2:0]         col_first;
  logic [2:0]         col_nxt;
  logic               start_idle;
  logic               count_en;
  logic               limit_hit;
  logic               advance;

  // tempo of 0 would give a zero-length step; treat it as one cycle per step
  assign tempo_eff  = (tempo == '0) ? TEMPO_W'(1) : tempo;
  assign limit_hit  = (tick == t_lim - TEMPO_W'(1));

  // pause outranks start, stop outranks both
  assign start_idle = (state == IDLE) && start && !stop && !pause;
  assign count_en   = !stop && !pause &&
                      ((state == RUN) || ((state == PAUSED) && start));
  assign advance    = count_en && limit_hit;

  assign step_nxt   = (step == 4'(NUM_STEPS - 1)) ? 4'd0 : step + 4'd1;

  // columns are read from the pre-write pattern values, so a same-edge
  // write only shows up from the following step entry
  assign col_first  = {pat2[0], pat1[0], pat0[0]};
  assign col_nxt    = {pat2[step_nxt], pat1[step_nxt], pat0[step_nxt]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!stop && !pause && start) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (pause) begin
          state_nxt = PAUSED;
        end
      end
      PAUSED: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (!pause && start) begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    running = (state == RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      step      <= 4'd0;
      tick      <= '0;
      t_lim     <= TEMPO_W'(1);
      go        <= 3'b000;
      bar_start <= 1'b0;
    end else if (stop) begin
      step      <= 4'd0;
      tick      <= '0;
      go        <= 3'b000;
      bar_start <= 1'b0;
    end else begin
      go        <= 3'b000;
      bar_start <= 1'b0;
      if (start_idle) begin
        step      <= 4'd0;
        tick      <= '0;
        t_lim     <= tempo_eff;
        go        <= col_first;
        bar_start <= 1'b1;
      end else if (advance) begin
        step      <= step_nxt;
        tick      <= '0;
        t_lim     <= tempo_eff;
        go        <= col_nxt;
        bar_start <= (step_nxt == 4'd0);
      end else if (count_en) begin
        tick <= tick + TEMPO_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pat0 <= 16'h0000;
      pat1 <= 16'h0000;
      pat2 <= 16'h0000;
    end else if (wr_en) begin
      case (wr_voice)
        2'd0:    pat0 <= wr_data;
        2'd1:    pat1 <= wr_data;
        2'd2:    pat2 <= wr_data;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_drum_sequencer.sv
// Bench for drum_sequencer: directed scenarios plus random command traffic,
// every cycle compared against a step/elapsed-time reference model.
module tb_drum_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic        stop = 1'b0;
  logic [22:0] tempo = 23'd1;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_voice = 2'd0;
  logic [15:0] wr_data = 16'h0000;
  logic [2:0]  go;
  logic [3:0]  step;
  logic        bar_start;
  logic        running;

  int compared = 0;
  int mismatched = 0;

  // reference model: 0 idle, 1 run, 2 paused
  int          m_state = 0;
  int          m_step = 0;
  int          m_elapsed = 0;
  int          m_len = 1;
  logic [15:0] m_pat [3];
  logic [2:0]  exp_go = 3'b000;
  logic        exp_bar = 1'b0;

  drum_sequencer #(.NUM_STEPS(16), .TEMPO_W(23)) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .stop(stop),
    .tempo(tempo), .wr_en(wr_en), .wr_voice(wr_voice), .wr_data(wr_data),
    .go(go), .step(step), .bar_start(bar_start), .running(running)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int eff_len();
    return (tempo == 23'd0) ? 1 : int'(tempo);
  endfunction

  task automatic m_enter();
    exp_go  = {m_pat[2][m_step], m_pat[1][m_step], m_pat[0][m_step]};
    exp_bar = (m_step == 0);
  endtask

  task automatic m_time();
    m_elapsed++;
    if (m_elapsed >= m_len) begin
      m_step    = (m_step + 1) % 16;
      m_elapsed = 0;
      m_len     = eff_len();
      m_enter();
    end
  endtask

  task automatic model_edge();
    exp_go  = 3'b000;
    exp_bar = 1'b0;
    if (reset) begin
      m_state = 0; m_step = 0; m_elapsed = 0; m_len = 1;
      m_pat[0] = 16'h0; m_pat[1] = 16'h0; m_pat[2] = 16'h0;
      return;
    end
    if (stop) begin
      m_state = 0; m_step = 0; m_elapsed = 0;
    end else begin
      case (m_state)
        0: if (start && !pause) begin
             m_state = 1; m_step = 0; m_elapsed = 0; m_len = eff_len();
             m_enter();
           end
        1: if (pause) m_state = 2;
           else m_time();
        default: if (start && !pause) begin
             m_state = 1;
             m_time();
           end
      endcase
    end
    if (wr_en && wr_voice != 2'd3) m_pat[wr_voice] = wr_data;
  endtask

  // one clock: model follows the edge, outputs sampled 1 time unit later
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("go", 32'(go), 32'(exp_go));
    chk("step", 32'(step), 32'(m_step));
    chk("bar_start", 32'(bar_start), 32'(exp_bar));
    chk("running", 32'(running), 32'(m_state == 1));
    start = 0; pause = 0; stop = 0; wr_en = 0; reset = 0;
  endtask

  task automatic write_pat(input logic [1:0] v, input logic [15:0] d);
    wr_en = 1; wr_voice = v; wr_data = d;
    cyc();
  endtask

  initial begin
    int n;
    int prev;
    m_pat[0] = 16'h0; m_pat[1] = 16'h0; m_pat[2] = 16'h0;

    // reset state
    reset = 1; cyc();
    reset = 1; cyc();
    chk("rst_go", 32'(go), 32'd0);
    chk("rst_step", 32'(step), 32'd0);
    chk("rst_running", 32'(running), 32'd0);

    // basic run
    write_pat(2'd0, 16'h1111);
    write_pat(2'd1, 16'h0101);
    write_pat(2'd2, 16'hFFFF);
    tempo = 23'd4;
    start = 1;
    for (int k = 1; k <= 66; k++) begin
      cyc();
      if (k == 1) begin
        chk("basic_go_c1", 32'(go), 32'b111);
        chk("basic_bar_c1", 32'(bar_start), 32'd1);
      end
      if (k == 5) begin
        chk("basic_go_c5", 32'(go), 32'b100);
        chk("basic_step_c5", 32'(step), 32'd1);
      end
      if (k == 65) begin
        chk("basic_wrap_step", 32'(step), 32'd0);
        chk("basic_wrap_bar", 32'(bar_start), 32'd1);
      end
    end

    // stop during step 7
    n = 0;
    while (m_step != 7 && n < 100) begin cyc(); n++; end
    chk("reach_step7", 32'(step), 32'd7);
    stop = 1; cyc();
    chk("stop_step", 32'(step), 32'd0);
    chk("stop_running", 32'(running), 32'd0);
    chk("stop_go", 32'(go), 32'd0);
    for (int k = 0; k < 6; k++) cyc();
    start = 1; stop = 1; cyc();
    chk("start_stop_idle", 32'(running), 32'd0);

    // pause / resume
    tempo = 23'd10;
    start = 1; cyc();
    n = 0;
    while (!(m_state == 1 && m_step == 2 && m_elapsed == 2) && n < 100) begin cyc(); n++; end
    chk("reach_step2", 32'(step), 32'd2);
    pause = 1; cyc();
    for (int k = 0; k < 19; k++) begin
      cyc();
      chk("paused_step", 32'(step), 32'd2);
      chk("paused_go", 32'(go), 32'd0);
    end
    start = 1; cyc();
    for (int k = 1; k <= 7; k++) begin
      cyc();
      chk("resume_step", 32'(step), (k == 7) ? 32'd3 : 32'd2);
    end
    pause = 1; start = 1; cyc();
    chk("pause_start_run", 32'(running), 32'd0);

    // tempo 0 with pat1 all ones
    stop = 1; cyc();
    write_pat(2'd1, 16'hFFFF);
    tempo = 23'd0;
    start = 1; cyc();
    for (int k = 0; k < 20; k++) begin
      prev = int'(step);
      cyc();
      chk("t0_go1", 32'(go[1]), 32'd1);
      chk("t0_step_inc", 32'(step), 32'((prev + 1) % 16));
    end

    // tempo change 4 -> 8 mid-step
    stop = 1; cyc();
    tempo = 23'd4;
    start = 1; cyc();
    tempo = 23'd8;
    n = 0;
    do begin cyc(); n++; end while (step == 4'd0 && n < 20);
    chk("len_old_tempo", 32'(n), 32'd4);
    n = 0;
    do begin cyc(); n++; end while (step == 4'd1 && n < 20);
    chk("len_new_tempo", 32'(n), 32'd8);

    // write collision on the 3 -> 4 advance
    stop = 1; cyc();
    write_pat(2'd0, 16'h0000);
    write_pat(2'd1, 16'h0000);
    write_pat(2'd2, 16'h0000);
    tempo = 23'd3;
    start = 1; cyc();
    n = 0;
    while (!(m_step == 3 && m_elapsed == m_len - 1) && n < 100) begin cyc(); n++; end
    wr_en = 1; wr_voice = 2'd0; wr_data = 16'hFFFF;
    cyc();
    chk("collide_step4", 32'(step), 32'd4);
    chk("collide_go0_s4", 32'(go[0]), 32'd0);
    n = 0;
    while (step != 4'd5 && n < 20) begin cyc(); n++; end
    chk("collide_go0_s5", 32'(go[0]), 32'd1);

    // reserved voice write
    wr_en = 1; wr_voice = 2'd3; wr_data = 16'hFFFF;
    cyc();
    prev = int'(step);
    n = 0;
    while (int'(step) == prev && n < 20) begin cyc(); n++; end
    chk("voice3_go", 32'(go), 32'b001);

    // reset mid-run
    reset = 1; cyc();
    chk("midrst_go", 32'(go), 32'd0);
    chk("midrst_running", 32'(running), 32'd0);
    chk("midrst_step", 32'(step), 32'd0);

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 8) start = 1;
      else if (r < 12) pause = 1;
      else if (r < 15) stop = 1;
      else if (r < 16) begin stop = 1; start = 1; end
      else if (r < 17) reset = 1;
      else if (r < 19 && m_state == 1) begin pause = 1; start = 1; end
      if ($urandom_range(0, 9) == 0) begin
        wr_en = 1;
        wr_voice = 2'($urandom_range(0, 3));
        wr_data = 16'($urandom);
      end
      if ($urandom_range(0, 19) == 0) tempo = 23'($urandom_range(0, 5));
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/drum_sequencer.md
DRUM_SEQUENCER -- requirements
Module: drum_sequencer

Interface
REQ-001 Parameter NUM_STEPS, default 16: steps per bar; fixed at 16 for this revision.
REQ-002 Parameter TEMPO_W, default 23: width of the tempo input and the tick counter.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  pulse; start from idle, or resume from pause.
REQ-006 pause  input  1  pulse; freeze playback position.
REQ-007 stop  input  1  pulse; abort playback and return to step 0.
REQ-008 tempo  input  TEMPO_W  clock cycles per step.
REQ-009 wr_en  input  1  pattern write strobe.
REQ-010 wr_voice  input  2  pattern select: 0=kick, 1=snare, 2=hihat; 3 is reserved.
REQ-011 wr_data  input  16  step mask; bit n enables the voice on step n.
REQ-012 go  output  3  one-cycle trigger per voice (bit 0 kick, bit 1 snare, bit 2 hihat), feeding each voice's sample counter go input.
REQ-013 step  output  4  current step index.
REQ-014 bar_start  output  1  one-cycle pulse marking entry into step 0.
REQ-015 running  output  1  high while the state is RUN.

Function
REQ-016 States: IDLE, RUN, PAUSED, in a 2-bit state register.
REQ-017 Priority each cycle: reset > stop > pause > start.
REQ-018 IDLE + start -> RUN.
  - step=0, tick=0.
  - Load tick limit T from tempo.
  - Next cycle: go = {pat2[0],pat1[0],pat0[0]}, bar_start=1.
REQ-019 In RUN, tick increments each cycle.
  - At tick==T-1: tick=0, step=(step+1) mod 16, reload T from tempo.
  - Next cycle: go = pattern column of the new step; bar_start=1 iff new step==0.
REQ-020 go and bar_start are registered, high for exactly one cycle per step entry, and 0 in all other cycles.
REQ-021 tempo==0 is treated as T=1: the step advances every cycle and go fires every cycle for the enabled voices.
REQ-022 tempo changes take effect only at the next step boundary or the next start from IDLE; the current step length never changes mid-step.
REQ-023 RUN + pause -> PAUSED.
  - step and tick hold.
  - No go pulses while PAUSED.
REQ-024 PAUSED + start -> RUN.
  - Counting resumes from the held tick.
  - No re-trigger of the current step.
REQ-025 stop in any state -> IDLE: step=0, tick=0, no go pulse that cycle or after.
REQ-026 Redundant commands are ignored:
  - start in RUN.
  - pause in IDLE or PAUSED.
  - stop in IDLE: harmless, state stays IDLE.
REQ-027 Simultaneous stop and start -> IDLE; simultaneous pause and start in RUN -> PAUSED.
REQ-028 wr_en=1 with wr_voice 0-2 writes wr_data into that pattern register at the clock edge; wr_voice=3 writes nothing.
REQ-029 Pattern writes are accepted in every state.
  - A write in the same cycle as a step advance does not affect that step's go.
  - It applies from the next step entry onward.
REQ-030 Step wraps 15 -> 0 with no idle gap; bar_start accompanies the wrap.
REQ-031 running = (state==RUN); step is a direct register output.

Reset
REQ-032 reset forces state=IDLE, step=0, tick=0, T=1, go=0, bar_start=0, running=0, and all three pattern registers to 16'h0000.
REQ-033 reset asserted mid-RUN takes effect at the next edge; no go pulse in the cycle after reset.

Verification
REQ-034 Basic run:
  - Stimulus: pat0=16'h1111, pat1=16'h0101, pat2=16'hFFFF, tempo=4, start at cycle 0.
  - Response: go=3'b111 and bar_start=1 at cycle 1; go=3'b100 at cycle 5; step=1 at cycle 5; step wraps to 0 with bar_start at cycle 65.
REQ-035 Pause/resume:
  - Stimulus: tempo=10; pause on the 3rd cycle of step 2; start 20 cycles later.
  - Response: step holds at 2 with no go pulses while paused; step 3 is entered 7 cycles after the resume edge.
REQ-036 Stop and priority:
  - Stimulus: stop during step 7; separately, start and stop asserted together in IDLE.
  - Response: after stop, step=0 and running=0 with no go pulses; the simultaneous case stays in IDLE.
REQ-037 Tempo edge:
  - Stimulus: tempo=0 with pat1=16'hFFFF.
  - Response: go[1]=1 every cycle and step increments every cycle.
  - Stimulus: tempo changed 4 -> 8 mid-step.
  - Response: the current step still lasts 4 cycles; the next step lasts 8.
REQ-038 Write collision:
  - Stimulus: write pat0=16'hFFFF in the cycle that advances from step 3 to step 4, with old pat0=0.
  - Response: no go[0] at step 4; go[0]=1 at step 5.
  - Stimulus: write with wr_voice=3.
  - Response: no pattern register changes.
